// File: rtl/motor_driver_output_stage.sv
// H-bridge gate driver bank: per-channel OFF/DEAD/FWD/REV sequencer that forces an
// all-low dead window before every turn-on or reversal; turn-off is immediate.
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | both legs low, idle
// DEAD  | both legs low, dead-time counter running before a new drive
// FWD   | drive_a high (forward leg)
// REV   | drive_b high (reverse leg)
module motor_driver_output_stage #(
    parameter int NUM_OF_DRIVERS = 16,
    parameter int DEAD_TIME      = 4,
    parameter int DEAD_CNT_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      output_active,
    input  logic                      update_cycle_complete,
    input  logic [NUM_OF_DRIVERS-1:0] inverter_select,
    input  logic [NUM_OF_DRIVERS-1:0] row_col_select,
    input  logic [NUM_OF_DRIVERS-1:0] row_data,
    input  logic [NUM_OF_DRIVERS-1:0] col_data,
    output logic [NUM_OF_DRIVERS-1:0] drive_a,
    output logic [NUM_OF_DRIVERS-1:0] drive_b,
    output logic [NUM_OF_DRIVERS-1:0] dead_active
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_FWD  = 2'd2,
        S_REV  = 2'd3
    } state_t;

    localparam logic [DEAD_CNT_WIDTH-1:0] DEAD_LOAD = DEAD_CNT_WIDTH'(DEAD_TIME - 1);

    logic cmd_off;
    assign cmd_off = ~output_active | update_cycle_complete;

    for (genvar i = 0; i < NUM_OF_DRIVERS; i++) begin : g_drv
        state_t                    state_q, state_d;
        logic [DEAD_CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                      cmd_fwd;
        logic                      a_q, b_q, dead_q;

        assign cmd_fwd = (row_col_select[i] ? col_data[i] : row_data[i]) ^ inverter_select[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF: begin
                    if (!cmd_off) begin
                        state_d = S_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                S_FWD: begin
                    if (cmd_off) begin
                        state_d = S_OFF;
                    end else if (!cmd_fwd) begin
                        state_d = S_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                S_REV: begin
                    if (cmd_off) begin
                        state_d = S_OFF;
                    end else if (cmd_fwd) begin
                        state_d = S_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                S_DEAD: begin
                    if (cmd_off) begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        // direction flips inside the window do not restart it
                        cnt_d = cnt_q - DEAD_CNT_WIDTH'(1);
                    end else begin
                        state_d = cmd_fwd ? S_FWD : S_REV;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                dead_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                a_q     <= (state_d == S_FWD);
                b_q     <= (state_d == S_REV);
                dead_q  <= (state_d == S_DEAD);
            end
        end

        assign drive_a[i]     = a_q;
        assign drive_b[i]     = b_q;
        assign dead_active[i] = dead_q;
    end

endmodule

// File: tb/tb_motor_driver_output_stage.sv
// Bench for motor_driver_output_stage: directed vector table, hand-written corner
// sequences, and randomized traffic against a per-driver behavioural model.
module tb_motor_driver_output_stage;

    localparam int N  = 16;
    localparam int DT = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         output_active = 1'b0;
    logic         update_cycle_complete = 1'b0;
    logic [N-1:0] inverter_select = '0;
    logic [N-1:0] row_col_select = '0;
    logic [N-1:0] row_data = '0;
    logic [N-1:0] col_data = '0;
    logic [N-1:0] drive_a, drive_b, dead_active;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    motor_driver_output_stage #(
        .NUM_OF_DRIVERS(N),
        .DEAD_TIME(DT),
        .DEAD_CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .output_active(output_active),
        .update_cycle_complete(update_cycle_complete),
        .inverter_select(inverter_select),
        .row_col_select(row_col_select),
        .row_data(row_data),
        .col_data(col_data),
        .drive_a(drive_a),
        .drive_b(drive_b),
        .dead_active(dead_active)
    );

    // Model: each driver holds what it is driving (0 none, 1 fwd, 2 rev) and how
    // many all-low cycles remain before the pending command may take effect.
    int m_drive [N];
    int m_wait  [N];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_drive[i] = 0;
            m_wait[i]  = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            int cmd;
            logic src;
            src = row_col_select[i] ? col_data[i] : row_data[i];
            if (!output_active || update_cycle_complete) cmd = 0;
            else cmd = (src ^ inverter_select[i]) ? 1 : 2;
            if (cmd == 0) begin
                m_drive[i] = 0;
                m_wait[i]  = 0;
            end else if (m_wait[i] > 0) begin
                if (m_wait[i] == 1) m_drive[i] = cmd;
                m_wait[i] = m_wait[i] - 1;
            end else if (cmd != m_drive[i]) begin
                m_drive[i] = 0;
                m_wait[i]  = DT;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_a();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_drive[i] == 1);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_b();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_drive[i] == 2);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_dead();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_wait[i] > 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model_drive_a", drive_a, exp_a());
        check("model_drive_b", drive_b, exp_b());
        check("model_dead", dead_active, exp_dead());
        check("no_overlap", drive_a & drive_b, '0);
    endtask

    typedef struct {
        logic         oa;
        logic         ucc;
        logic [N-1:0] inv;
        logic [N-1:0] rcs;
        logic [N-1:0] row;
        logic [N-1:0] col;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [N-1:0] ed;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // basic drive: driver 0 forward, the rest reverse
        for (int k = 0; k < 4; k++)
            tbl[k] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'hFFFE, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'hFFFE, 16'h0000};
        // sequence end dominates an active window
        tbl[6] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        // inversion and column source: everything resolves reverse
        for (int k = 9; k < 13; k++)
            tbl[k] = '{1'b1, 1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'hFFFF};
        tbl[13] = '{1'b1, 1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000};

        #2 reset = 1'b1;
        #1;
        check("reset_a", drive_a, '0);
        check("reset_b", drive_b, '0);
        check("reset_dead", dead_active, '0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            output_active         = tbl[k].oa;
            update_cycle_complete = tbl[k].ucc;
            inverter_select       = tbl[k].inv;
            row_col_select        = tbl[k].rcs;
            row_data              = tbl[k].row;
            col_data              = tbl[k].col;
            tick();
            check("tbl_a", drive_a, tbl[k].ea);
            check("tbl_b", drive_b, tbl[k].eb);
            check("tbl_dead", dead_active, tbl[k].ed);
        end

        // reversal on driver 0
        inverter_select = '0;
        row_col_select  = '0;
        row_data        = 16'h0001;
        output_active   = 1'b1;
        repeat (DT + 1) tick();
        check("rev_start_fwd", N'(drive_a[0]), N'(1'b1));
        row_data = 16'h0000;
        tick();
        check("rev_a_falls", N'(drive_a[0]), N'(1'b0));
        check("rev_dead_on", N'(dead_active[0]), N'(1'b1));
        for (int k = 1; k < DT; k++) begin
            tick();
            check("rev_window_low", N'({drive_a[0], drive_b[0]}), N'(2'b00));
        end
        tick();
        check("rev_b_rises", N'(drive_b[0]), N'(1'b1));
        check("rev_dead_off", N'(dead_active[0]), N'(1'b0));

        // abort inside the dead window, then a full fresh window
        output_active = 1'b0;
        tick();
        row_data      = 16'h0001;
        output_active = 1'b1;
        tick();
        tick();
        output_active = 1'b0;
        tick();
        check("abort_off", N'({dead_active[0], drive_a[0]}), N'(2'b00));
        output_active = 1'b1;
        for (int k = 0; k < DT; k++) begin
            tick();
            check("abort_fresh_dead", N'({dead_active[0], drive_a[0]}), N'(2'b10));
        end
        tick();
        check("abort_then_fwd", N'(drive_a[0]), N'(1'b1));

        // asynchronous reset mid-drive
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("areset_a", drive_a, '0);
        check("areset_b", drive_b, '0);
        check("areset_dead", dead_active, '0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < DT; k++) begin
            tick();
            check("post_reset_low", N'(drive_a[0]), N'(1'b0));
        end
        tick();
        check("post_reset_fwd", N'(drive_a[0]), N'(1'b1));

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            output_active         = ($urandom_range(0, 15) != 0);
            update_cycle_complete = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) row_data = N'($urandom);
            if ($urandom_range(0, 7) == 0) col_data = N'($urandom);
            if ($urandom_range(0, 31) == 0) inverter_select = N'($urandom);
            if ($urandom_range(0, 31) == 0) row_col_select = N'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
